// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher helpers: inverse S-box, GF(2^8) arithmetic,
// InvMixColumns on one column and InvShiftRows on a whole block.
package aes_pkg;
   localparam int AES_BLK_W = 128;
   localparam int AES_NB    = 4;

   // [col][row]; byte 0 (row 0, col 0) lands in the block MSBs
   typedef logic [0:3][0:3][7:0] aes_state_t;

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
      aes_state_t i, o;
      i = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[c][r] = i[(c + 4 - r) % 4][r];
      return o;
   endfunction
endpackage

// File: rtl/aes_decrypt_iterative_if.sv
// Ciphertext-in / plaintext-out valid/ready handshakes of the AES decryptor.
interface aes_decrypt_iterative_if;
   import aes_pkg::*;
   logic                 in_valid;
   logic                 in_ready;
   logic [AES_BLK_W-1:0] in_cipher;
   logic                 out_valid;
   logic                 out_ready;
   logic [AES_BLK_W-1:0] out_msg;

   modport master (output in_valid, in_cipher, out_ready,
                   input  in_ready, out_valid, out_msg);
   modport slave  (input  in_valid, in_cipher, out_ready,
                   output in_ready, out_valid, out_msg);
endinterface

// File: rtl/aes_decrypt_iterative_inv_round.sv
// One combinational AES inverse round; last=1 skips InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] state,
   input  logic [AES_BLK_W-1:0] round_key,
   input  logic                 last,
   output logic [AES_BLK_W-1:0] next_state
);
   logic [AES_BLK_W-1:0] sr, sb, ak, mc;

   assign sr = inv_shift_rows(state);

   for (genvar k = 0; k < 16; k++) begin : g_sub
      assign sb[8*k +: 8] = inv_sbox(sr[8*k +: 8]);
   end

   assign ak = sb ^ round_key;

   for (genvar c = 0; c < AES_NB; c++) begin : g_mix
      assign mc[32*c +: 32] = inv_mix_column(ak[32*c +: 32]);
   end

   assign next_state = last ? ak : mc;
endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher, one round per clock, fed by the keyExpansion schedule w.
// Optional AES_DEC_KEY_LATCH_EN: latch w at accept so it may change mid-block.
module aes_decrypt_iterative
   import aes_pkg::*;
#(
   parameter int nk = 4,
   parameter int nb = 4,
   parameter int nr = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   aes_decrypt_iterative_if.slave  bus,
   input  logic [32*nb*(nr+1)-1:0] w
);
   localparam int KW = 32*nb*(nr+1);
   localparam int RW = $clog2(nr+1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] FINAL = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   if (nr != nk + 6 || nb != AES_NB) begin : g_cfg_err
      $error("aes_decrypt_iterative: needs nb=4 and nr=nk+6");
   end

   logic [1:0]           state;
   logic [RW-1:0]        rnd, ridx;
   logic [AES_BLK_W-1:0] st, nxt, out_msg_q;
   logic                 out_valid_q, accept;
   logic [KW-1:0]        key_src;
   logic [AES_BLK_W-1:0] rk [0:nr];

   assign bus.in_ready  = rst_n && (state == IDLE || (state == DONE && bus.out_ready));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_msg   = out_msg_q;

`ifdef AES_DEC_KEY_LATCH_EN
   logic [KW-1:0] key_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      key_q <= '0;
      else if (accept) key_q <= w;
   end
   assign key_src = key_q;
`else
   assign key_src = w;
`endif

   for (genvar r = 0; r <= nr; r++) begin : g_rk
      assign rk[r] = key_src[KW-1-AES_BLK_W*r -: AES_BLK_W];
   end

   assign ridx = (state == FINAL) ? '0 : rnd;

   aes_inv_round u_round (
      .state      (st),
      .round_key  (rk[ridx]),
      .last       (state == FINAL),
      .next_state (nxt)
   );

   // Initial AddRoundKey reads w directly: a latched key is not yet visible at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rnd         <= '0;
         st          <= '0;
         out_valid_q <= 1'b0;
         out_msg_q   <= '0;
      end else if (accept) begin
         st          <= bus.in_cipher ^ w[AES_BLK_W-1:0];
         rnd         <= RW'(nr - 1);
         state       <= (nr == 1) ? FINAL : ROUND;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ROUND: begin
               st  <= nxt;
               rnd <= rnd - RW'(1);
               if (rnd == RW'(1)) state <= FINAL;
            end
            FINAL: begin
               out_msg_q   <= nxt;
               out_valid_q <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Directed FIPS-197 vectors for the iterative AES decryptor (nr = 10/12/14),
// with its own S-box and key schedule to build w.
module tb_aes_decrypt_iterative;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_decrypt_iterative_if if10 ();
   aes_decrypt_iterative_if if12 ();
   aes_decrypt_iterative_if if14 ();
   logic [1407:0] w10;
   logic [1663:0] w12;
   logic [1919:0] w14;

   aes_decrypt_iterative #(.nk(4), .nb(4), .nr(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave), .w(w10));
   aes_decrypt_iterative #(.nk(6), .nb(4), .nr(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave), .w(w12));
   aes_decrypt_iterative #(.nk(8), .nb(4), .nr(14)) dut14 (.clk(clk), .rst_n(rst_n), .bus(if14.slave), .w(w14));

   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

   typedef struct {
      int           nr;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      string        name;
   } vec_t;
   vec_t tbl [4];

   int nchk = 0;
   int nerr = 0;
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Forward S-box from the field inverse plus the affine map.
   task automatic build_sbox();
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      rc = 8'h01;
      r  = '0;
      for (int i = 0; i < 4*(nk+7); i++) begin
         if (i < nk) wd[i] = key[255-32*i -: 32];
         else begin
            t = wd[i-1];
            if (i % nk == 0) begin
               t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            wd[i] = wd[i-nk] ^ t;
         end
         r[1919-32*i -: 32] = wd[i];
      end
      return r;
   endfunction

   task automatic set_key(input int nr, input logic [255:0] key);
      logic [1919:0] ex;
      ex = expand(key, nr - 6);
      case (nr)
         10:      w10 = ex[1919 -: 1408];
         12:      w12 = ex[1919 -: 1664];
         default: w14 = ex;
      endcase
   endtask

   task automatic drive(input int nr, input logic v, input logic [127:0] ct);
      case (nr)
         10:      begin if10.in_valid = v; if10.in_cipher = ct; end
         12:      begin if12.in_valid = v; if12.in_cipher = ct; end
         default: begin if14.in_valid = v; if14.in_cipher = ct; end
      endcase
   endtask

   function automatic logic get_ir(input int nr);
      case (nr)
         10:      return if10.in_ready;
         12:      return if12.in_ready;
         default: return if14.in_ready;
      endcase
   endfunction

   function automatic logic get_ov(input int nr);
      case (nr)
         10:      return if10.out_valid;
         12:      return if12.out_valid;
         default: return if14.out_valid;
      endcase
   endfunction

   function automatic logic [127:0] get_om(input int nr);
      case (nr)
         10:      return if10.out_msg;
         12:      return if12.out_msg;
         default: return if14.out_msg;
      endcase
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic accept(input int nr, input logic [127:0] ct, input string name);
      drive(nr, 1'b1, ct);
      #1;
      check({name, " in_ready"}, 128'(get_ir(nr)), 128'(1));
      @(posedge clk);
      @(negedge clk);
      drive(nr, 1'b0, ct);
   endtask

   // eq=0 requires the plaintext to differ from exp.
   task automatic wait_out(input int nr, input logic [127:0] exp, input bit eq, input string name);
      int lat;
      lat = 0;
      while (!get_ov(nr) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 128'(lat), 128'(nr));
      if (eq) check({name, " out_msg"}, get_om(nr), exp);
      else begin
         nchk++;
         if (get_om(nr) === exp) begin
            nerr++;
            $display("FAIL %s out_msg: got %h, required a value differing from %h", name, get_om(nr), exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      if10.in_valid = 1'b0; if10.in_cipher = '0; if10.out_ready = 1'b1;
      if12.in_valid = 1'b0; if12.in_cipher = '0; if12.out_ready = 1'b1;
      if14.in_valid = 1'b0; if14.in_cipher = '0; if14.out_ready = 1'b1;
      build_sbox();
      tbl[0] = '{10, KEY_C1, CT_C1, PT,   "aes128 C.1"};
      tbl[1] = '{10, KEY_B,  CT_B,  PT_B, "aes128 B"};
      tbl[2] = '{12, KEY_C2, CT_C2, PT,   "aes192 C.2"};
      tbl[3] = '{14, KEY_C3, CT_C3, PT,   "aes256 C.3"};
      set_key(10, KEY_C1);
      set_key(12, KEY_C2);
      set_key(14, KEY_C3);

      #12;
      check("reset in_ready",  128'(if10.in_ready),  128'(0));
      check("reset out_valid", 128'(if10.out_valid), 128'(0));
      check("reset out_msg",   if10.out_msg,         128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle in_ready", 128'(if10.in_ready), 128'(1));
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         set_key(tbl[i].nr, tbl[i].key);
         accept(tbl[i].nr, tbl[i].ct, tbl[i].name);
         wait_out(tbl[i].nr, tbl[i].pt, 1'b1, tbl[i].name);
         @(negedge clk);
      end

      // Backpressure, then back-to-back accept in the consuming cycle
      set_key(10, KEY_C1);
      if10.out_ready = 1'b0;
      accept(10, CT_C1, "bp first");
      wait_out(10, PT, 1'b1, "bp first");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp hold out_valid", 128'(if10.out_valid), 128'(1));
         check("bp hold out_msg",   if10.out_msg,         PT);
         check("bp hold in_ready",  128'(if10.in_ready),  128'(0));
      end
      if10.out_ready = 1'b1;
      set_key(10, KEY_B);
      accept(10, CT_B, "bp second");
      check("bp consumed out_valid", 128'(if10.out_valid), 128'(0));
      wait_out(10, PT_B, 1'b1, "bp second");
      @(negedge clk);

      // Reset in the middle of a block
      set_key(10, KEY_C1);
      accept(10, CT_C1, "pre-abort");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 128'(if10.out_valid), 128'(0));
      check("abort out_msg",   if10.out_msg,         128'(0));
      check("abort in_ready",  128'(if10.in_ready),  128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (if10.out_valid) bad++;
      end
      check("abort no out_valid", 128'(bad), 128'(0));
      accept(10, CT_C1, "post-abort");
      wait_out(10, PT, 1'b1, "post-abort");
      @(negedge clk);

      // in_valid held with other data while rounds run
      accept(10, CT_C1, "ignore");
      drive(10, 1'b1, CT_B);
      #1;
      check("ignore in_ready in ROUND", 128'(if10.in_ready), 128'(0));
      wait_out(10, PT, 1'b1, "ignore");
      drive(10, 1'b0, CT_B);
      @(negedge clk);
      check("ignore idle out_valid", 128'(if10.out_valid), 128'(0));
      @(negedge clk);

      // w cleared one cycle after accept
      accept(10, CT_C1, "key change");
      w10 = '0;
`ifdef AES_DEC_KEY_LATCH_EN
      wait_out(10, PT, 1'b1, "key change");
`else
      wait_out(10, PT, 1'b0, "key change");
`endif
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
